oled_screen_scheduler: RTL and testbench

// Sequences which game screen drives the 96x64 OLED. Holds the game-flow FSM: title, menu, level, pause, game-over.

---
 rtl/oled_pkg.sv | 37 +++
 rtl/oled_screen_scheduler_if.sv | 27 ++
 rtl/oled_xy_map.sv | 42 ++++
 rtl/oled_screen_scheduler.sv | 147 ++++++++++++++
 tb/tb_oled_screen_scheduler.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/oled_pkg.sv
// Shared constants and types for the OLED screen scheduler: panel geometry, RGB565 colours,
// screen indices and game-flow state encoding.
package oled_pkg;

  localparam int unsigned OLED_W = 96;
  localparam int unsigned OLED_H = 64;

  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] GREEN = 16'h07E0;
  localparam logic [15:0] BLUE  = 16'h001F;

  localparam logic [2:0] SCR_TITLE  = 3'd0;
  localparam logic [2:0] SCR_MENU   = 3'd1;
  localparam logic [2:0] SCR_LEVEL1 = 3'd2;
  localparam logic [2:0] SCR_LEVEL2 = 3'd3;
  localparam logic [2:0] SCR_LEVEL3 = 3'd4;
  localparam logic [2:0] SCR_OVER   = 3'd5;

  typedef enum logic [2:0] {
    StTitle,
    StMenu,
    StGame,
    StPause,
    StOver
  } state_e;

  // Pending input events, highest priority first.
  typedef struct packed {
    logic go;
    logic c;
    logic u;
    logic d;
  } events_t;

endpackage

// File: rtl/oled_screen_scheduler_if.sv
// Bundle between the OLED driver / game logic / renderers and the screen scheduler.
interface oled_screen_scheduler_if #(
  parameter int unsigned NScreens = 6
);
  logic                    frame_begin;
  logic [12:0]             pixel_index;
  logic                    btn_c;
  logic                    btn_u;
  logic                    btn_d;
  logic                    game_over;
  logic [16*NScreens-1:0]  screen_data;
  logic [6:0]              x;
  logic [5:0]              y;
  logic [2:0]              screen_sel;
  logic [1:0]              menu_sel;
  logic [15:0]             oled_data;

  modport master (
    output frame_begin, pixel_index, btn_c, btn_u, btn_d, game_over, screen_data,
    input  x, y, screen_sel, menu_sel, oled_data
  );

  modport slave (
    input  frame_begin, pixel_index, btn_c, btn_u, btn_d, game_over, screen_data,
    output x, y, screen_sel, menu_sel, oled_data
  );
endinterface

// File: rtl/oled_xy_map.sv
// Registers the driver's linear pixel index as column/row; indices past the panel map to 0,0.
module oled_xy_map
  import oled_pkg::*;
#(
  parameter int unsigned Width  = OLED_W,
  parameter int unsigned Height = OLED_H
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] pixel_index_i,
  output logic [6:0]  x_o,
  output logic [5:0]  y_o
);

  localparam int unsigned NumPix = Width * Height;

  logic [6:0] x_d, x_q;
  logic [5:0] y_d, y_q;

  always_comb begin
    x_d = '0;
    y_d = '0;
    if (32'(pixel_index_i) < NumPix) begin
      x_d = 7'(pixel_index_i % 13'(Width));
      y_d = 6'(pixel_index_i / 13'(Width));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule

// File: rtl/oled_screen_scheduler.sv
// Game-flow FSM for the OLED: picks the active screen, commits changes only at frame_begin,
// and muxes the selected renderer pixel (or black during pause blink-off) to the driver.
module oled_screen_scheduler
  import oled_pkg::*;
#(
  parameter int unsigned Width       = OLED_W,
  parameter int unsigned Height      = OLED_H,
  parameter int unsigned BlinkFrames = 15,
  parameter int unsigned OverFrames  = 180
) (
  input logic                    clk,
  input logic                    rst_n,
  oled_screen_scheduler_if.slave bus
);

  state_e      state_q, state_d;
  logic [1:0]  level_q, level_d;
  logic [1:0]  menu_q, menu_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        blink_q, blink_d;
  events_t     pend_q, pend_d, pulse, ev;
  logic        in_play;
  logic [2:0]  sel;
  logic        blank;
  logic [15:0] oled_d, oled_q;

  oled_xy_map #(
    .Width  (Width),
    .Height (Height)
  ) u_xy_map (
    .clk           (clk),
    .rst_n         (rst_n),
    .pixel_index_i (bus.pixel_index),
    .x_o           (bus.x),
    .y_o           (bus.y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StTitle;
      level_q <= '0;
      menu_q  <= '0;
      cnt_q   <= '0;
      blink_q <= 1'b0;
      pend_q  <= '0;
      oled_q  <= BLACK;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      menu_q  <= menu_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      pend_q  <= pend_d;
      oled_q  <= oled_d;
    end
  end

  always_comb begin
    pulse   = {bus.game_over, bus.btn_c, bus.btn_u, bus.btn_d};
    in_play = (state_q == StGame) || (state_q == StPause);

    // Events that do not apply to the current state neither act nor block lower ones.
    ev      = '0;
    ev.go   = pend_q.go & in_play;
    ev.c    = pend_q.c & ~ev.go;
    ev.u    = pend_q.u & (state_q == StMenu) & ~pend_q.c;
    ev.d    = pend_q.d & (state_q == StMenu) & ~pend_q.c & ~pend_q.u;

    // A pulse arriving with frame_begin belongs to the following frame.
    pend_d  = bus.frame_begin ? pulse : (pend_q | pulse);

    state_d = state_q;
    level_d = level_q;
    menu_d  = menu_q;
    cnt_d   = cnt_q;
    blink_d = blink_q;

    if (bus.frame_begin) begin
      unique case (state_q)
        StTitle: if (ev.c) state_d = StMenu;
        StMenu: begin
          if (ev.c) begin
            state_d = StGame;
            level_d = menu_q;
          end else if (ev.u) begin
            menu_d = (menu_q == 2'd0) ? 2'd2 : menu_q - 2'd1;
          end else if (ev.d) begin
            menu_d = (menu_q == 2'd2) ? 2'd0 : menu_q + 2'd1;
          end
        end
        StGame: begin
          if (ev.go) begin
            state_d = StOver;
            cnt_d   = '0;
          end else if (ev.c) begin
            state_d = StPause;
            cnt_d   = '0;
            blink_d = 1'b0;
          end
        end
        StPause: begin
          if (ev.go) begin
            state_d = StOver;
            cnt_d   = '0;
          end else if (ev.c) begin
            state_d = StGame;
          end else if (cnt_q == 8'(BlinkFrames - 1)) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StOver: begin
          if (ev.c || (cnt_q == 8'(OverFrames - 1))) begin
            state_d = StTitle;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = StTitle;
      endcase
    end
  end

  always_comb begin
    sel   = SCR_TITLE;
    blank = 1'b0;
    unique case (state_q)
      StTitle: sel = SCR_TITLE;
      StMenu:  sel = SCR_MENU;
      StGame:  sel = SCR_LEVEL1 + {1'b0, level_q};
      StPause: begin
        sel   = SCR_LEVEL1 + {1'b0, level_q};
        blank = blink_q;
      end
      StOver:  sel = SCR_OVER;
      default: sel = SCR_TITLE;
    endcase
    oled_d = blank ? BLACK : bus.screen_data[{sel, 4'b0000} +: 16];
  end

  assign bus.screen_sel = sel;
  assign bus.menu_sel   = menu_q;
  assign bus.oled_data  = oled_q;

endmodule

// File: tb/tb_oled_screen_scheduler.sv
// Directed bench for oled_screen_scheduler: a frame-level game-flow model checked every cycle,
// plus hand-computed literal checks at the key points of each scenario.
module tb_oled_screen_scheduler;
  localparam int FP = 8;  // cycles per frame in this bench

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  oled_screen_scheduler_if #(.NScreens(6)) bus ();

  oled_screen_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: 0 title, 1 menu, 2 game, 3 pause, 4 over
  int m_mode, m_level, m_menu, m_pause_fr, m_over_fr;
  bit p_go, p_c, p_u, p_d;
  int e_x, e_y, e_sel, e_menu, e_oled;
  bit cmp_en = 1'b0;
  int cyc = 0;
  int pix_fix = -1;
  logic [95:0] sdata = 96'h6666_5555_4444_3333_2222_1111;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int sel_of();
    case (m_mode)
      0: return 0;
      1: return 1;
      2, 3: return 2 + m_level;
      default: return 5;
    endcase
  endfunction

  function automatic bit blank_of();
    return (m_mode == 3) && (((m_pause_fr / 15) % 2) == 1);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_level = 0; m_menu = 0; m_pause_fr = 0; m_over_fr = 0;
    p_go = 0; p_c = 0; p_u = 0; p_d = 0;
    e_x = 0; e_y = 0; e_sel = 0; e_menu = 0; e_oled = 0;
  endtask

  task automatic apply_frame();
    if (p_go && (m_mode == 2 || m_mode == 3)) begin
      m_mode = 4; m_over_fr = 0;
    end else if (p_c) begin
      case (m_mode)
        0: m_mode = 1;
        1: begin m_level = m_menu; m_mode = 2; end
        2: begin m_mode = 3; m_pause_fr = 0; end
        3: m_mode = 2;
        default: m_mode = 0;
      endcase
    end else if (m_mode == 1 && p_u) begin
      m_menu = (m_menu + 2) % 3;
    end else if (m_mode == 1 && p_d) begin
      m_menu = (m_menu + 1) % 3;
    end else if (m_mode == 3) begin
      m_pause_fr++;
    end else if (m_mode == 4) begin
      if (m_over_fr + 1 >= 180) m_mode = 0;
      else m_over_fr++;
    end
  endtask

  // Called just after a rising edge, with the inputs of that edge still applied.
  task automatic model_step();
    int pi;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pi = int'(bus.pixel_index);
    e_oled = blank_of() ? 0 : int'(sdata[16*sel_of() +: 16]);
    if (pi < 96 * 64) begin
      e_x = pi % 96;
      e_y = pi / 96;
    end else begin
      e_x = 0;
      e_y = 0;
    end
    if (bus.frame_begin) begin
      apply_frame();
      p_go = bus.game_over; p_c = bus.btn_c; p_u = bus.btn_u; p_d = bus.btn_d;
    end else begin
      p_go |= bus.game_over; p_c |= bus.btn_c; p_u |= bus.btn_u; p_d |= bus.btn_d;
    end
    e_sel  = sel_of();
    e_menu = m_menu;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("x", int'(bus.x), e_x);
      chk("y", int'(bus.y), e_y);
      chk("screen_sel", int'(bus.screen_sel), e_sel);
      chk("menu_sel", int'(bus.menu_sel), e_menu);
      chk("oled_data", int'(bus.oled_data), e_oled);
    end
  end

  task automatic cycle(input bit c, input bit u, input bit d, input bit go);
    bus.frame_begin = (cyc % FP == 0);
    bus.pixel_index = (pix_fix >= 0) ? 13'(pix_fix) : 13'((cyc * 389) % 6300);
    bus.btn_c = c;
    bus.btn_u = u;
    bus.btn_d = d;
    bus.game_over = go;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic goto_pos(input int k);
    while (cyc % FP != k) idle();
  endtask

  task automatic next_frame();
    goto_pos(0);
    idle();
  endtask

  initial begin
    bus.frame_begin = 1'b0;
    bus.pixel_index = 13'd200;
    bus.btn_c = 1'b0;
    bus.btn_u = 1'b0;
    bus.btn_d = 1'b0;
    bus.game_over = 1'b0;
    bus.screen_data = sdata;
    model_reset();
    #2;
    rst_n = 1'b0;
    cmp_en = 1'b1;
    pix_fix = 200;
    cyc = 1;
    idle();
    idle();
    chk("rst_x", int'(bus.x), 0);
    chk("rst_y", int'(bus.y), 0);
    chk("rst_oled", int'(bus.oled_data), 0);
    chk("rst_sel", int'(bus.screen_sel), 0);
    rst_n = 1'b1;
    idle();
    idle();
    chk("rel_x", int'(bus.x), 8);
    chk("rel_y", int'(bus.y), 2);
    chk("rel_oled", int'(bus.oled_data), 16'h1111);
    pix_fix = -1;

    // btn_c together with frame_begin takes effect one frame later
    goto_pos(0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("c_coinc_hold0", int'(bus.screen_sel), 0);
    goto_pos(0);
    chk("c_coinc_hold1", int'(bus.screen_sel), 0);
    idle();
    chk("c_coinc_menu", int'(bus.screen_sel), 1);

    // menu navigation with wrap, and game_over ignored in MENU
    goto_pos(3);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("menu_hold", int'(bus.menu_sel), 0);
    next_frame();
    chk("menu_up_wrap", int'(bus.menu_sel), 2);
    goto_pos(3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    next_frame();
    chk("menu_dn_wrap", int'(bus.menu_sel), 0);
    goto_pos(3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    next_frame();
    chk("menu_dn", int'(bus.menu_sel), 1);
    goto_pos(2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    next_frame();
    chk("go_in_menu", int'(bus.screen_sel), 1);
    goto_pos(3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    next_frame();
    chk("game_lvl2", int'(bus.screen_sel), 3);

    // pause blink: visible 0..14, black 15..29, visible again at 30
    goto_pos(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    goto_pos(3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    next_frame();
    chk("pause_sel", int'(bus.screen_sel), 3);
    goto_pos(4);
    chk("pause_f0", int'(bus.oled_data), 16'h4444);
    for (int f = 1; f <= 31; f++) begin
      next_frame();
      goto_pos(4);
      chk($sformatf("pause_f%0d", f), int'(bus.oled_data),
          (f >= 15 && f < 30) ? 0 : 16'h4444);
    end
    goto_pos(5);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    next_frame();
    for (int f = 0; f < 20; f++) begin
      goto_pos(4);
      chk($sformatf("resume_f%0d", f), int'(bus.oled_data), 16'h4444);
      next_frame();
    end

    // game_over beats btn_c; OVER times out after 180 frames
    goto_pos(2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    goto_pos(5);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    next_frame();
    chk("over_sel", int'(bus.screen_sel), 5);
    for (int f = 1; f < 180; f++) next_frame();
    chk("over_179", int'(bus.screen_sel), 5);
    next_frame();
    chk("over_timeout", int'(bus.screen_sel), 0);

    // btn_c mid-frame in TITLE
    goto_pos(3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    goto_pos(0);
    chk("c_mid_hold", int'(bus.screen_sel), 0);
    idle();
    chk("c_mid_menu", int'(bus.screen_sel), 1);

    // async reset mid-frame while paused
    goto_pos(3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    next_frame();
    goto_pos(3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    next_frame();
    next_frame();
    goto_pos(3);
    chk("pre_rst_oled", int'(bus.oled_data), 16'h4444);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_oled", int'(bus.oled_data), 0);
    chk("async_rst_sel", int'(bus.screen_sel), 0);
    idle();
    idle();
    rst_n = 1'b1;
    idle();
    idle();
    chk("post_rst_sel", int'(bus.screen_sel), 0);
    chk("post_rst_oled", int'(bus.oled_data), 16'h1111);
    next_frame();
    next_frame();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
